// File: rtl/nco_dual_core_if.sv
// AXI4-Stream sample link carrying the packed {ch1, ch0} NCO output.
interface nco_dual_core_if #(
  parameter int unsigned DW = 16
);
  logic [2*DW-1:0] tdata;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/nco_dual_core.sv
// Dual phase-continuous sine NCO: strobe divider, two phase accumulators,
// full-wave sine ROM and a two-stage AXI4-Stream pipeline with overrun counting.
module nco_dual_core #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LUT_AW  = 10,
  parameter int unsigned DW      = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_enable,
  input  logic                 cfg_phase_clr,
  input  logic [PHASE_W-1:0]   cfg_fcw0,
  input  logic [PHASE_W-1:0]   cfg_fcw1,
  input  logic [PHASE_W-1:0]   cfg_poff1,
  input  logic [15:0]          cfg_rate,
  nco_dual_core_if.master      m_axis,
  output logic [CNT_W-1:0]     overrun_cnt,
  output logic                 busy
);

  localparam real PI = 3.14159265358979323846;

  // Taylor series on [-pi, pi]; 24 terms keep the error far below one LSB.
  function automatic real sin_r(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int unsigned n = 1; n < 24; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic signed [DW-1:0] lut_entry(input int k);
    real ph;
    real v;
    int  r;
    ph = 2.0 * PI * real'(k) / (2.0 ** LUT_AW);
    if (ph > PI) ph = ph - 2.0 * PI;
    v = ((2.0 ** (DW - 1)) - 1.0) * sin_r(ph);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return r[DW-1:0];
  endfunction

  logic signed [DW-1:0] lut [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    localparam logic signed [DW-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  logic [15:0]         div_cnt;
  logic                strobe;
  logic                stall;
  logic                take;
  logic [PHASE_W-1:0]  acc0;
  logic [PHASE_W-1:0]  acc1;
  logic [LUT_AW-1:0]   addr0;
  logic [LUT_AW-1:0]   addr1;
  logic [LUT_AW-1:0]   acc0_top;
  logic [LUT_AW-1:0]   phase1_top;
  logic [LUT_AW-1:0]   poff1_top;
  logic                s1_valid;

  assign strobe     = cfg_enable && (div_cnt == '0);
  assign stall      = m_axis.tvalid && !m_axis.tready;
  assign take       = strobe && !stall;
  assign acc0_top   = acc0[PHASE_W-1 -: LUT_AW];
  assign poff1_top  = cfg_poff1[PHASE_W-1 -: LUT_AW];
  assign phase1_top = LUT_AW'((acc1 + cfg_poff1) >> (PHASE_W - LUT_AW));
  assign busy       = s1_valid || m_axis.tvalid;

  // Divider keeps running through stalls so dropped strobes are still counted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
    end else if (!cfg_enable) begin
      div_cnt <= '0;
    end else if (div_cnt == '0) begin
      div_cnt <= cfg_rate;
    end else begin
      div_cnt <= div_cnt - 16'd1;
    end
  end

  // Clear wins over accumulation; a clear on an accepted strobe leaves acc = fcw.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (cfg_phase_clr) begin
      acc0 <= take ? cfg_fcw0 : '0;
      acc1 <= take ? cfg_fcw1 : '0;
    end else if (take) begin
      acc0 <= acc0 + cfg_fcw0;
      acc1 <= acc1 + cfg_fcw1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid      <= 1'b0;
      addr0         <= '0;
      addr1         <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= strobe;
      if (strobe) begin
        addr0 <= cfg_phase_clr ? '0        : acc0_top;
        addr1 <= cfg_phase_clr ? poff1_top : phase1_top;
      end
      m_axis.tdata  <= {lut[addr1], lut[addr0]};
      m_axis.tvalid <= s1_valid;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overrun_cnt <= '0;
    end else if (strobe && stall && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule
